// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit single-cycle CPU: opcode constants,
// the ALU operation encoding, datapath widths and the opcode/func decoder.
`timescale 1ns/1ps
package cpu_pkg;

  localparam int WIDTH = 16;
  localparam int IMM_W = 7;

  // Major opcodes, instruction[15:13]
  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LW    = 3'b010;
  localparam logic [2:0] OP_SW    = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_JMP   = 3'b101;
  localparam logic [2:0] OP_ANDI  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  // R-type uses func[2:0] directly unless func[3] is set; every other
  // opcode that needs address or immediate arithmetic falls back to ADD.
  function automatic alu_op_e decode_alu_op(input logic [2:0] opcode,
                                            input logic [3:0] func);
    alu_op_e op;
    case (opcode)
      OP_RTYPE: op = func[3] ? ALU_ADD : alu_op_e'(func[2:0]);
      OP_BEQ:   op = ALU_SUB;
      OP_ANDI:  op = ALU_AND;
      default:  op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 16-bit ALU: result, carry (no-borrow on SUB), zero and
// signed overflow. Overflow is only computed when ALU_OVERFLOW_EN is
// defined; otherwise it is tied low.
`timescale 1ns/1ps
module alu_core
  import cpu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          alu_code,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             is_zero,
  output logic             overflow
);

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;

  // Carry-out forms: subtraction as A + ~B + 1 so carry=1 means no borrow.
  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  end

  // Operation select; every output gets a default before the case.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
    result = '0;
    carry  = 1'b0;
    case (alu_code)
      ALU_ADD: {carry, result} = sum_ext;
      ALU_SUB: {carry, result} = diff_ext;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: result = a << b[3:0];
      ALU_SRL: result = a >> b[3:0];
      default: result = '0;
    endcase
  end

  // Zero flag is taken from the final result, so BEQ sees A==B here.
  assign is_zero = (result == '0);

`ifdef ALU_OVERFLOW_EN
  // Signed overflow for ADD (same-sign operands, result sign differs) and
  // SUB (operand signs differ, result sign differs from A).
  always_comb begin
    overflow = 1'b0;
    case (alu_code)
      ALU_ADD: overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      ALU_SUB: overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      default: overflow = 1'b0;
    endcase
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage of the 16-bit single-cycle CPU: opcode/func decode, operand
// B select (register or sign-extended immediate), ALU, and a status flag
// register holding the last committed carry/zero/overflow.
// Optional feature macro: ALU_OVERFLOW_EN (signed overflow flag and ovf_q).
`timescale 1ns/1ps
module alu_exec_unit
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic [3:0]       func,
  input  logic             alusrc,
  input  logic [WIDTH-1:0] read1,
  input  logic [WIDTH-1:0] read2,
  input  logic [IMM_W-1:0] immediate,
  input  logic             flag_we,
  output logic [2:0]       alu_code,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             is_zero,
  output logic             overflow,
  output logic             carry_q,
  output logic             zero_q,
  output logic             ovf_q
);

  alu_op_e          alu_op;
  logic [WIDTH-1:0] imm_sext;

  // Decode and operand-B select are pure combinational, zero latency.
  always_comb begin
    alu_op   = decode_alu_op(opcode, func);
    imm_sext = {{(WIDTH-IMM_W){immediate[IMM_W-1]}}, immediate};
    alu_b    = alusrc ? imm_sext : read2;
    alu_code = alu_op;
  end

  alu_core u_alu_core (
    .a        (read1),
    .b        (alu_b),
    .alu_code (alu_op),
    .result   (result),
    .carry    (carry),
    .is_zero  (is_zero),
    .overflow (overflow)
  );

  // Status flags: synchronous reset dominates, otherwise load on flag_we.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (flag_we) begin
      carry_q <= carry;
      zero_q  <= is_zero;
    end
  end

`ifdef ALU_OVERFLOW_EN
  // Overflow status flag, same reset/load rules as carry and zero.
  always_ff @(posedge clk) begin
    if (rst)          ovf_q <= 1'b0;
    else if (flag_we) ovf_q <= overflow;
  end
`else
  assign ovf_q = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: an arithmetic reference model is
// compared against every output on each falling edge, and hand-computed
// literal vectors pin both the model and the DUT.
`timescale 1ns/1ps
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  opcode;
  logic [3:0]  func;
  logic        alusrc;
  logic [15:0] read1, read2;
  logic [6:0]  immediate;
  logic        flag_we;
  logic [2:0]  alu_code;
  logic [15:0] alu_b, result;
  logic        carry, is_zero, overflow, carry_q, zero_q, ovf_q;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

`ifdef ALU_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .alusrc(alusrc),
    .read1(read1), .read2(read2), .immediate(immediate), .flag_we(flag_we),
    .alu_code(alu_code), .alu_b(alu_b), .result(result), .carry(carry),
    .is_zero(is_zero), .overflow(overflow), .carry_q(carry_q),
    .zero_q(zero_q), .ovf_q(ovf_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  code;
    logic [15:0] b;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        ov;
  } exp_t;

  // Reference model in plain integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [3:0] fn,
                                 input logic src, input logic [15:0] a,
                                 input logic [15:0] r2, input logic [6:0] imm);
    exp_t e;
    int   ua, ub, sa, sb, si, s;
    si = (int'(imm) >= 64) ? int'(imm) - 128 : int'(imm);
    e.b = src ? 16'(si) : r2;
    case (op)
      3'd0:    e.code = fn[3] ? 3'd0 : fn[2:0];
      3'd4:    e.code = 3'd1;
      3'd6:    e.code = 3'd2;
      default: e.code = 3'd0;
    endcase
    ua = int'(a);
    ub = int'(e.b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    e.c  = 1'b0;
    e.ov = 1'b0;
    case (e.code)
      3'd0: begin
        s = ua + ub; e.res = 16'(s); e.c = (s > 65535);
        e.ov = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      end
      3'd1: begin
        e.res = 16'(ua - ub); e.c = (ua >= ub);
        e.ov = ((sa - sb) > 32767) || ((sa - sb) < -32768);
      end
      3'd2:    e.res = a & e.b;
      3'd3:    e.res = a | e.b;
      3'd4:    e.res = a ^ e.b;
      3'd5:    e.res = (sa < sb) ? 16'd1 : 16'd0;
      3'd6:    e.res = 16'(ua * (2 ** (ub % 16)));
      default: e.res = 16'(ua / (2 ** (ub % 16)));
    endcase
    e.z = (e.res == 16'd0);
    if (!OVF_ON) e.ov = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the flag register.
  logic mq_c, mq_z, mq_o;
  always @(posedge clk) begin
    exp_t m;
    m = model(opcode, func, alusrc, read1, read2, immediate);
    if (rst) begin
      mq_c <= 1'b0; mq_z <= 1'b0; mq_o <= 1'b0;
    end else if (flag_we) begin
      mq_c <= m.c; mq_z <= m.z; mq_o <= m.ov;
    end
  end

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      exp_t m;
      m = model(opcode, func, alusrc, read1, read2, immediate);
      check("m_alu_code", 32'(alu_code), 32'(m.code));
      check("m_alu_b",    32'(alu_b),    32'(m.b));
      check("m_result",   32'(result),   32'(m.res));
      check("m_carry",    32'(carry),    32'(m.c));
      check("m_is_zero",  32'(is_zero),  32'(m.z));
      check("m_overflow", 32'(overflow), 32'(m.ov));
      check("m_carry_q",  32'(carry_q),  32'(mq_c));
      check("m_zero_q",   32'(zero_q),   32'(mq_z));
      check("m_ovf_q",    32'(ovf_q),    32'(mq_o));
    end
  end

  // Drive one instruction just after a rising edge, return at the falling edge.
  task automatic apply(input logic [2:0] op, input logic [3:0] fn, input logic src,
                       input logic [15:0] a, input logic [15:0] r2,
                       input logic [6:0] imm, input logic we, input logic r);
    @(posedge clk);
    #1;
    opcode = op; func = fn; alusrc = src; read1 = a; read2 = r2;
    immediate = imm; flag_we = we; rst = r;
    @(negedge clk);
  endtask

  logic [15:0] a_vec [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8001};
  logic [15:0] b_vec [4] = '{16'h0001, 16'h8000, 16'h1234, 16'h0003};

  initial begin
    // Reset asserted while an ADD FFFF+1 with flag_we=1 is presented: reset wins.
    rst = 1'b1; opcode = 3'b000; func = 4'b0000; alusrc = 1'b0;
    read1 = 16'hFFFF; read2 = 16'h0001; immediate = 7'h00; flag_we = 1'b1;
    repeat (2) @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk);
    check("rst_carry_q", 32'(carry_q), 32'd0);
    check("rst_zero_q",  32'(zero_q),  32'd0);
    check("rst_ovf_q",   32'(ovf_q),   32'd0);

    // R-type ADD wrap-around, committed into the flags.
    apply(3'b000, 4'b0000, 1'b0, 16'hFFFF, 16'h0001, 7'h00, 1'b1, 1'b0);
    check("add_wrap_result", 32'(result),  32'h0000);
    check("add_wrap_carry",  32'(carry),   32'd1);
    check("add_wrap_zero",   32'(is_zero), 32'd1);

    // SUB 0-1 with flag_we=0; flags now show the committed ADD.
    apply(3'b000, 4'b0001, 1'b0, 16'h0000, 16'h0001, 7'h00, 1'b0, 1'b0);
    check("sub_wrap_result", 32'(result), 32'hFFFF);
    check("sub_wrap_carry",  32'(carry),  32'd0);
    check("flag_load_c",     32'(carry_q), 32'd1);
    check("flag_load_z",     32'(zero_q),  32'd1);

    // ADDI with negative immediate; flags must still hold.
    apply(3'b001, 4'b0000, 1'b1, 16'h0010, 16'h5555, 7'h7F, 1'b0, 1'b0);
    check("addi_alu_b",  32'(alu_b),  32'hFFFF);
    check("addi_result", 32'(result), 32'h000F);
    check("addi_carry",  32'(carry),  32'd1);
    check("flag_hold_c", 32'(carry_q), 32'd1);
    check("flag_hold_z", 32'(zero_q),  32'd1);

    // BEQ equal and unequal.
    apply(3'b100, 4'b0000, 1'b0, 16'h1234, 16'h1234, 7'h00, 1'b0, 1'b0);
    check("beq_code", 32'(alu_code), 32'd1);
    check("beq_zero", 32'(is_zero),  32'd1);
    apply(3'b100, 4'b0000, 1'b0, 16'h1234, 16'h1235, 7'h00, 1'b0, 1'b0);
    check("beq_ne_result", 32'(result),  32'hFFFF);
    check("beq_ne_carry",  32'(carry),   32'd0);
    check("beq_ne_zero",   32'(is_zero), 32'd0);

    // Shifts and SLT.
    apply(3'b000, 4'b0110, 1'b0, 16'h0001, 16'h000F, 7'h00, 1'b0, 1'b0);
    check("sll_15", 32'(result), 32'h8000);
    apply(3'b000, 4'b0111, 1'b0, 16'h8000, 16'h0004, 7'h00, 1'b0, 1'b0);
    check("srl_4", 32'(result), 32'h0800);
    apply(3'b000, 4'b0110, 1'b0, 16'hA5A5, 16'h0010, 7'h00, 1'b0, 1'b0);
    check("sll_0", 32'(result), 32'hA5A5);
    apply(3'b000, 4'b0101, 1'b0, 16'hFFFF, 16'h0001, 7'h00, 1'b0, 1'b0);
    check("slt_neg", 32'(result), 32'h0001);
    check("slt_carry", 32'(carry), 32'd0);

    // ANDI and func[3] fallback to ADD.
    apply(3'b110, 4'b0000, 1'b1, 16'h1234, 16'h0000, 7'h0F, 1'b0, 1'b0);
    check("andi_code",   32'(alu_code), 32'd2);
    check("andi_result", 32'(result),   32'h0004);
    apply(3'b000, 4'b1111, 1'b0, 16'h0002, 16'h0003, 7'h00, 1'b0, 1'b0);
    check("func3_add_code",   32'(alu_code), 32'd0);
    check("func3_add_result", 32'(result),   32'h0005);

    // Signed overflow cases, committed to ovf_q.
    apply(3'b000, 4'b0000, 1'b0, 16'h7FFF, 16'h0001, 7'h00, 1'b1, 1'b0);
    check("ovf_add", 32'(overflow), 32'(OVF_ON));
    apply(3'b000, 4'b0001, 1'b0, 16'h8000, 16'h0001, 7'h00, 1'b0, 1'b0);
    check("ovf_sub",   32'(overflow), 32'(OVF_ON));
    check("ovf_q_add", 32'(ovf_q),    32'(OVF_ON));

    // Reset with flag_we=1 on a flag-setting op clears everything.
    apply(3'b000, 4'b0000, 1'b0, 16'hFFFF, 16'h0001, 7'h00, 1'b1, 1'b1);
    apply(3'b000, 4'b0000, 1'b0, 16'h0001, 16'h0001, 7'h00, 1'b0, 1'b0);
    check("rst_we_carry_q", 32'(carry_q), 32'd0);
    check("rst_we_zero_q",  32'(zero_q),  32'd0);
    check("rst_we_ovf_q",   32'(ovf_q),   32'd0);

    // Sweep of every opcode/func with a few operand pairs, model-checked.
    for (int op = 0; op < 8; op++) begin
      for (int fn = 0; fn < 16; fn++) begin
        for (int k = 0; k < 4; k++) begin
          apply(3'(op), 4'(fn), 1'(k & 1), a_vec[k], b_vec[(k + fn) % 4],
                7'(fn * 9 + k), 1'($urandom_range(0, 1)), 1'b0);
        end
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
